vga_draw_arbiter: RTL and testbench

Shares the single VGA framebuffer write port between up to N pixel-drawing engines (paddles, ball, score, game-over banner). Each engine requests the port, receives an exclusive one-hot grant, streams x/y/color/plot until it signals done, then releases. Round-robin arbitration prevents starvation; a hold-time watchdog revokes a stuck engine. Output feeds the VGA adapter write port directly.

---
 rtl/vga_draw_arbiter_pkg.sv | 18 +
 rtl/rr_pick.sv | 28 ++
 rtl/vga_draw_arbiter.sv | 134 +++++++++++++
 tb/tb_vga_draw_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer draw arbiter: FSM encoding,
// screen geometry and the palette entries the drawing engines use.
package vga_draw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_RED   = 3'b100;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit found
// searching upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  always_comb begin
    int k;
    winner = '0;
    valid  = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = i + int'(ptr);
      if (k >= N) k = k - N;
      if (!valid && req[k]) begin
        winner[k] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA framebuffer write port, with a
// hold-time watchdog and one dead cycle between consecutive owners.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int          N        = 4,
  parameter logic [15:0] MAX_HOLD = 16'd40000,
  parameter int          X_MAX    = SCREEN_W,
  parameter int          Y_MAX    = SCREEN_H,
  localparam int         PW       = $clog2(N)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  input  logic [8*N-1:0] x_in,
  input  logic [7*N-1:0] y_in,
  input  logic [3*N-1:0] color_in,
  input  logic [N-1:0]   plot_in,
  output logic [N-1:0]   grant,
  output logic [7:0]     x_out,
  output logic [6:0]     y_out,
  output logic [2:0]     color_out,
  output logic           plot_out,
  output logic           busy,
  output logic           timeout
);

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] gidx_reg;
  logic [15:0]   hold_cnt_reg;

  logic [7:0] x_arr     [N];
  logic [6:0] y_arr     [N];
  logic [2:0] color_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign x_arr[gi]     = x_in[8*gi +: 8];
    assign y_arr[gi]     = y_in[7*gi +: 7];
    assign color_arr[gi] = color_in[3*gi +: 3];
  end

  logic [N-1:0]  pick_onehot;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_onehot[i]) pick_idx = PW'(i);
    end
  end

  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_color;
  logic       sel_plot, sel_done, sel_req, in_bounds, wd_hit, exit_active;

  always_comb begin
    sel_x       = x_arr[gidx_reg];
    sel_y       = y_arr[gidx_reg];
    sel_color   = color_arr[gidx_reg];
    sel_plot    = plot_in[gidx_reg];
    sel_done    = done[gidx_reg];
    sel_req     = req[gidx_reg];
    in_bounds   = (32'(sel_x) < X_MAX) && (32'(sel_y) < Y_MAX);
    wd_hit      = (hold_cnt_reg == MAX_HOLD - 16'd1);
    exit_active = sel_done || !sel_req || wd_hit;

    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_valid) state_next = ST_ACTIVE;
      ST_ACTIVE:  if (exit_active) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      gidx_reg     <= '0;
      hold_cnt_reg <= '0;
      grant        <= '0;
      x_out        <= '0;
      y_out        <= '0;
      color_out    <= '0;
      plot_out     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_reg <= state_next;
      timeout   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          plot_out <= 1'b0;
          if (pick_valid) begin
            grant        <= pick_onehot;
            gidx_reg     <= pick_idx;
            hold_cnt_reg <= '0;
          end
        end
        ST_ACTIVE: begin
          hold_cnt_reg <= hold_cnt_reg + 16'd1;
          x_out        <= sel_x;
          y_out        <= sel_y;
          color_out    <= sel_color;
          plot_out     <= sel_plot && in_bounds;
          if (exit_active) begin
            grant   <= '0;
            // a completing or abandoning engine is never reported as stuck
            timeout <= wd_hit && !sel_done && sel_req;
          end
        end
        ST_RELEASE: begin
          plot_out <= 1'b0;
          ptr_reg  <= (gidx_reg == PW'(N - 1)) ? '0 : gidx_reg + 1'b1;
        end
        default: plot_out <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench: directed scenarios plus randomized engines, all
// outputs compared every cycle against a transaction-level port model.
module tb_vga_draw_arbiter;
  import vga_draw_arbiter_pkg::*;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int X_MAX    = 160;
  localparam int Y_MAX    = 120;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req, done, plot_in;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] color_in;
  logic [N-1:0]   grant;
  logic [7:0]     x_out;
  logic [6:0]     y_out;
  logic [2:0]     color_out;
  logic           plot_out, busy, timeout;

  vga_draw_arbiter #(
    .N(N), .MAX_HOLD(16'(MAX_HOLD)), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .plot_in(plot_in),
    .grant(grant), .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .plot_out(plot_out), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Port model: who owns the port, how long it has held it, and whether the
  // mandatory idle gap after an owner is still pending.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  bit         m_gap   = 0;
  logic [N-1:0] e_grant = '0;
  logic [7:0] e_x = '0;
  logic [6:0] e_y = '0;
  logic [2:0] e_color = '0;
  logic       e_plot = 0, e_busy = 0, e_timeout = 0;
  logic [N-1:0] prev_grant = '0;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (!resetn) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_gap = 0;
      e_grant = '0; e_x = '0; e_y = '0; e_color = '0;
      e_plot = 0; e_busy = 0; e_timeout = 0;
    end else if (m_gap) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 0;
      e_grant = '0; e_plot = 0; e_timeout = 0; e_busy = 0;
    end else if (m_owner < 0) begin
      e_plot = 0; e_timeout = 0;
      w = first_from(req, m_ptr);
      e_grant = '0;
      e_busy = (w >= 0);
      if (w >= 0) begin
        m_owner = w; m_held = 0; e_grant[w] = 1'b1;
      end
    end else begin
      e_x     = x_in[8*m_owner +: 8];
      e_y     = y_in[7*m_owner +: 7];
      e_color = color_in[3*m_owner +: 3];
      e_plot  = plot_in[m_owner] && (e_x < X_MAX) && (e_y < Y_MAX);
      m_held++;
      e_busy = 1; e_timeout = 0;
      if (done[m_owner] || !req[m_owner]) begin
        m_gap = 1; e_grant = '0;
      end else if (m_held == MAX_HOLD) begin
        m_gap = 1; e_grant = '0; e_timeout = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("grant", grant, e_grant);
    check("x_out", x_out, e_x);
    check("y_out", y_out, e_y);
    check("color_out", color_out, e_color);
    check("plot_out", plot_out, e_plot);
    check("busy", busy, e_busy);
    check("timeout", timeout, e_timeout);
    if (grant != 0 && prev_grant == 0) $display("[%0t] grant %b", $time, grant);
    if (timeout) $display("[%0t] watchdog revoked %b", $time, prev_grant);
    prev_grant = grant;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c, input bit p);
    x_in[8*i +: 8]     = 8'(x);
    y_in[7*i +: 7]     = 7'(y);
    color_in[3*i +: 3] = 3'(c);
    plot_in[i]         = p;
  endtask

  task automatic do_reset();
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
  endtask

  int n;
  int len [N];
  bit was_g [N];

  initial begin
    resetn = 1'b0; req = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; color_in = '0;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_plot", plot_out, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1; tick();

    // single request, engine 2 draws five green pixels at (10,20)
    req = 4'b0100; tick();
    check("single_grant", grant, 4'b0100);
    set_pix(2, 10, 20, COLOR_GREEN, 1);
    for (int k = 0; k < 5; k++) begin
      done[2] = (k == 4);
      tick();
      check("single_plot", plot_out, 1);
      check("single_x", x_out, 10);
      check("single_y", y_out, 20);
      check("single_color", color_out, 3'b010);
    end
    check("single_release", grant, 0);
    done = '0; plot_in = '0; req = '0; tick(); tick();

    // round-robin with all engines requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == 0 && n < 10) begin tick(); n++; end
      check("rr_gap", n, (k == 0) ? 1 : 2);
      check("rr_order", grant, 4'b0001 << (k % 4));
      tick(); tick();
      done = grant; tick(); done = '0;
      check("rr_drop", grant, 0);
    end
    req = '0; tick(); tick();

    // screen bounds on the forwarded write enable
    req = 4'b0010; tick();
    check("bnd_grant", grant, 4'b0010);
    set_pix(1, 160, 5, COLOR_RED, 1);   tick(); check("bnd_x160", plot_out, 0);
    set_pix(1, 159, 119, COLOR_RED, 1); tick(); check("bnd_in", plot_out, 1);
    set_pix(1, 10, 120, COLOR_RED, 1);  tick(); check("bnd_y120", plot_out, 0);
    done[1] = 1; plot_in = '0; tick(); done = '0; req = '0; tick(); tick();

    // watchdog on a stuck engine 1, then engine 2 finishing in its 8th cycle
    do_reset();
    req = 4'b0110; tick();
    check("wd_grant1", grant, 4'b0010);
    n = 0;
    do begin tick(); n++; end while (!timeout && n < 20);
    check("wd_cycles", n, MAX_HOLD);
    check("wd_drop", grant, 0);
    req = 4'b0100; tick();
    check("wd_pulse", timeout, 0);
    tick();
    check("wd_next", grant, 4'b0100);
    for (int k = 0; k < MAX_HOLD - 1; k++) tick();
    done[2] = 1; tick(); done = '0;
    check("wd_done_no_to", timeout, 0);
    check("wd_done_drop", grant, 0);
    req = '0; tick(); tick();

    // non-granted noise is ignored, then engine 0 abandons
    do_reset();
    req = 4'b1001; tick();
    check("ab_grant", grant, 4'b0001);
    done[3] = 1; plot_in = 4'b1000; tick();
    check("ab_noise_grant", grant, 4'b0001);
    check("ab_noise_plot", plot_out, 0);
    done = '0; plot_in = '0; req = 4'b1000; tick();
    check("ab_release", grant, 0);
    check("ab_no_to", timeout, 0);
    tick(); tick();
    check("ab_next", grant, 4'b1000);
    done[3] = 1; tick(); done = '0; req = '0; tick(); tick();

    // reset in the middle of a grant clears the pointer too
    req = 4'b0010; tick(); done[1] = 1; tick(); done = '0; req = '0; tick(); tick();
    req = 4'b0100; tick();
    check("mr_grant", grant, 4'b0100);
    set_pix(2, 30, 40, COLOR_RED, 1); tick();
    resetn = 1'b0; tick();
    check("mr_grant0", grant, 0);
    check("mr_plot0", plot_out, 0);
    check("mr_x0", x_out, 0);
    resetn = 1'b1; plot_in = '0; req = 4'b0101; tick();
    check("mr_ptr0", grant, 4'b0001);
    done[0] = 1; tick(); done = '0; req = '0; tick(); tick();

    // randomized engines
    do_reset();
    for (int i = 0; i < N; i++) begin len[i] = 0; was_g[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      done = '0;
      for (int i = 0; i < N; i++) begin
        if (was_g[i] && !grant[i]) begin
          req[i] = 0; was_g[i] = 0;
        end else if (grant[i]) begin
          was_g[i] = 1;
          if ($urandom_range(0, 29) == 0) req[i] = 0;
          else if (len[i] <= 1) done[i] = 1;
          else len[i]--;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1; len[i] = $urandom_range(1, 12);
        end else begin
          done[i] = ($urandom_range(0, 7) == 0);
        end
        set_pix(i, $urandom_range(0, 175), $urandom_range(0, 127),
                $urandom_range(0, 7), $urandom_range(0, 1));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
